// File: rtl/apb_arbiter_if.sv
// Signal bundle between the two APB masters, the arbiter and the shared APB slave bus.
// The arbiter connects through the slave modport; the surrounding system drives the master modport.
interface apb_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m0_paddr;
    logic [DATA_WIDTH-1:0] m0_pdata;
    logic                  m0_psel;
    logic                  m0_penable;
    logic                  m0_pwrite;
    logic [3:0]            m0_pstb;
    logic [DATA_WIDTH-1:0] m0_prdata;
    logic                  m0_pready;
    logic                  m0_perr;

    logic [ADDR_WIDTH-1:0] m1_paddr;
    logic [DATA_WIDTH-1:0] m1_pdata;
    logic                  m1_psel;
    logic                  m1_penable;
    logic                  m1_pwrite;
    logic [3:0]            m1_pstb;
    logic [DATA_WIDTH-1:0] m1_prdata;
    logic                  m1_pready;
    logic                  m1_perr;

    logic [ADDR_WIDTH-1:0] APB_paddr;
    logic [DATA_WIDTH-1:0] APB_pdata;
    logic                  APB_psel;
    logic                  APB_penable;
    logic                  APB_pwrite;
    logic [3:0]            APB_pstb;
    logic [DATA_WIDTH-1:0] APB_prdata;
    logic                  APB_pready;
    logic                  APB_perr;

    logic                  grant;

    // The arbiter is the slave of both masters and the master of the APB bus.
    modport slave (
        input  m0_paddr, m0_pdata, m0_psel, m0_penable, m0_pwrite, m0_pstb,
        output m0_prdata, m0_pready, m0_perr,
        input  m1_paddr, m1_pdata, m1_psel, m1_penable, m1_pwrite, m1_pstb,
        output m1_prdata, m1_pready, m1_perr,
        output APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
        input  APB_prdata, APB_pready, APB_perr,
        output grant
    );

    modport master (
        output m0_paddr, m0_pdata, m0_psel, m0_penable, m0_pwrite, m0_pstb,
        input  m0_prdata, m0_pready, m0_perr,
        output m1_paddr, m1_pdata, m1_psel, m1_penable, m1_pwrite, m1_pstb,
        input  m1_prdata, m1_pready, m1_perr,
        input  APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
        output APB_prdata, APB_pready, APB_perr,
        input  grant
    );
endinterface

// File: rtl/apb_arbiter.sv
// Two-master APB arbiter: round-robin ownership of one APB bus with a per-transfer
// ready-timeout watchdog. Slave responses are passed combinationally to the owner.
module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic          APB_PCLK,
    input  logic          APB_PRESETn,
    apb_arbiter_if.slave  bus
);
    localparam int         NM           = 2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_reg;
    logic                  owner_reg;
    logic                  last_owner_reg;
    logic [7:0]            count_reg;
    logic [ADDR_WIDTH-1:0] paddr_reg;
    logic [DATA_WIDTH-1:0] pdata_reg;
    logic                  pwrite_reg;
    logic [3:0]            pstb_reg;
    logic                  psel_reg;
    logic                  penable_reg;

    logic [NM-1:0]         req;
    logic [ADDR_WIDTH-1:0] m_paddr  [NM];
    logic [DATA_WIDTH-1:0] m_pdata  [NM];
    logic [NM-1:0]         m_pwrite;
    logic [3:0]            m_pstb   [NM];
    logic [NM-1:0]         resp_sel;
    logic [NM-1:0]         m_pready;
    logic [NM-1:0]         m_perr;
    logic [DATA_WIDTH-1:0] m_prdata [NM];

    logic other_owner;
    logic idle_owner;
    logic load_owner;
    logic load_en;
    logic xfer_done;
    logic xfer_timeout;
    logic xfer_end;

    // Masters' access-phase strobes carry no information the arbiter needs.
    logic unused_penable;
    assign unused_penable = bus.m0_penable ^ bus.m1_penable;

    assign req         = {bus.m1_psel, bus.m0_psel};
    assign m_paddr[0]  = bus.m0_paddr;
    assign m_paddr[1]  = bus.m1_paddr;
    assign m_pdata[0]  = bus.m0_pdata;
    assign m_pdata[1]  = bus.m1_pdata;
    assign m_pwrite    = {bus.m1_pwrite, bus.m0_pwrite};
    assign m_pstb[0]   = bus.m0_pstb;
    assign m_pstb[1]   = bus.m1_pstb;

    always_comb begin
        other_owner  = ~owner_reg;
        // Prefer the master that was not served last; otherwise the lone requester.
        idle_owner   = req[~last_owner_reg] ? ~last_owner_reg : req[1];
        xfer_done    = (state_reg == ACCESS) && bus.APB_pready;
        xfer_timeout = (state_reg == ACCESS) && !bus.APB_pready && (count_reg == TIMEOUT_LAST);
        xfer_end     = xfer_done || xfer_timeout;
        load_en      = ((state_reg == IDLE) && (|req)) ||
                       (xfer_done && req[other_owner]);
        load_owner   = (state_reg == IDLE) ? idle_owner : other_owner;
    end

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            count_reg      <= '0;
            paddr_reg      <= '0;
            pdata_reg      <= '0;
            pwrite_reg     <= 1'b0;
            pstb_reg       <= '0;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
        end else begin
            if (load_en) begin
                paddr_reg  <= m_paddr[load_owner];
                pdata_reg  <= m_pdata[load_owner];
                pwrite_reg <= m_pwrite[load_owner];
                pstb_reg   <= m_pstb[load_owner];
                owner_reg  <= load_owner;
            end
            case (state_reg)
                IDLE: begin
                    if (load_en) begin
                        state_reg <= SETUP;
                        psel_reg  <= 1'b1;
                    end
                end
                SETUP: begin
                    state_reg   <= ACCESS;
                    penable_reg <= 1'b1;
                end
                ACCESS: begin
                    if (xfer_end) begin
                        last_owner_reg <= owner_reg;
                        count_reg      <= '0;
                        if (load_en) begin
                            // Back-to-back handover to the other master, no idle cycle.
                            state_reg   <= SETUP;
                            penable_reg <= 1'b0;
                        end else begin
                            state_reg   <= IDLE;
                            psel_reg    <= 1'b0;
                            penable_reg <= 1'b0;
                        end
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    psel_reg    <= 1'b0;
                    penable_reg <= 1'b0;
                end
            endcase
        end
    end

    // A response reaches a master only if it owns the bus and is still selecting.
    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_resp
            assign resp_sel[gi] = xfer_end && req[gi] && (owner_reg == 1'(gi));
            assign m_pready[gi] = resp_sel[gi];
            assign m_perr[gi]   = resp_sel[gi] && (xfer_timeout || bus.APB_perr);
            assign m_prdata[gi] = (resp_sel[gi] && xfer_done) ? bus.APB_prdata : '0;
        end
    endgenerate

    assign bus.m0_pready   = m_pready[0];
    assign bus.m0_perr     = m_perr[0];
    assign bus.m0_prdata   = m_prdata[0];
    assign bus.m1_pready   = m_pready[1];
    assign bus.m1_perr     = m_perr[1];
    assign bus.m1_prdata   = m_prdata[1];

    assign bus.APB_paddr   = paddr_reg;
    assign bus.APB_pdata   = pdata_reg;
    assign bus.APB_pwrite  = pwrite_reg;
    assign bus.APB_pstb    = pstb_reg;
    assign bus.APB_psel    = psel_reg;
    assign bus.APB_penable = penable_reg;
    assign bus.grant       = owner_reg;
endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench for apb_arbiter: directed master transfers push expected bus setups and
// master responses; an independent monitor pops and compares them as the DUT presents them.
module tb_apb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .APB_PCLK    (clk),
        .APB_PRESETn (rst_n),
        .bus         (bus_if)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } resp_t;

    typedef struct {
        logic        owner;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [3:0]  stb;
        int          at;
        bit          b2b;
    } bus_t;

    resp_t exp_r0[$];
    resp_t exp_r1[$];
    bus_t  exp_b[$];

    int total = 0;
    int bad   = 0;

    logic [31:0] slave_data = 32'hDEADBEEF;
    int          slave_wait = 0;
    bit          slave_hang = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic exp_resp(input int m, input logic [31:0] rdata, input logic err, input int at);
        resp_t r;
        r.rdata = rdata;
        r.err   = err;
        r.at    = at;
        if (m == 0) exp_r0.push_back(r);
        else        exp_r1.push_back(r);
    endtask

    task automatic exp_bus(input logic owner, input logic [31:0] addr, input logic [31:0] data,
                           input logic wr, input logic [3:0] stb, input int at, input bit b2b);
        bus_t b;
        b.owner = owner;
        b.addr  = addr;
        b.data  = data;
        b.wr    = wr;
        b.stb   = stb;
        b.at    = at;
        b.b2b   = b2b;
        exp_b.push_back(b);
    endtask

    task automatic clear_masters();
        bus_if.m0_paddr = '0; bus_if.m0_pdata = '0; bus_if.m0_psel = 1'b0;
        bus_if.m0_penable = 1'b0; bus_if.m0_pwrite = 1'b0; bus_if.m0_pstb = '0;
        bus_if.m1_paddr = '0; bus_if.m1_pdata = '0; bus_if.m1_psel = 1'b0;
        bus_if.m1_penable = 1'b0; bus_if.m1_pwrite = 1'b0; bus_if.m1_pstb = '0;
    endtask

    // Returns at posedge+1 with the DUT idle.
    task automatic do_reset();
        clear_masters();
        slave_hang = 1'b0;
        slave_wait = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the cycle in which pready was seen.
    task automatic master_xfer(input int m, input logic [31:0] addr, input logic [31:0] data,
                               input logic wr, input logic [3:0] stb, input bit hold);
        int n    = 0;
        bit seen = 1'b0;
        if (m == 0) begin
            bus_if.m0_paddr = addr; bus_if.m0_pdata = data; bus_if.m0_pwrite = wr;
            bus_if.m0_pstb = stb; bus_if.m0_psel = 1'b1; bus_if.m0_penable = 1'b0;
        end else begin
            bus_if.m1_paddr = addr; bus_if.m1_pdata = data; bus_if.m1_pwrite = wr;
            bus_if.m1_pstb = stb; bus_if.m1_psel = 1'b1; bus_if.m1_penable = 1'b0;
        end
        while (!seen && n < 50) begin
            @(negedge clk);
            #2;
            seen = (m == 0) ? bus_if.m0_pready : bus_if.m1_pready;
            n++;
            if (m == 0) bus_if.m0_penable = 1'b1;
            else        bus_if.m1_penable = 1'b1;
        end
        chk($sformatf("m%0d_xfer_wait", m), 128'(seen), 128'(1));
        @(posedge clk);
        #1;
        if (m == 0) begin
            bus_if.m0_penable = 1'b0;
            if (!hold) bus_if.m0_psel = 1'b0;
        end else begin
            bus_if.m1_penable = 1'b0;
            if (!hold) bus_if.m1_psel = 1'b0;
        end
    endtask

    // Slave: answers after slave_wait ACCESS cycles; addresses 0xE....... return an error.
    initial begin : slave
        int acc;
        acc = 0;
        bus_if.APB_pready = 1'b0;
        bus_if.APB_perr   = 1'b0;
        bus_if.APB_prdata = '0;
        forever begin
            @(negedge clk);
            if (bus_if.APB_psel && bus_if.APB_penable) begin
                if (acc >= slave_wait && !slave_hang) begin
                    bus_if.APB_pready = 1'b1;
                    bus_if.APB_prdata = slave_data ^ bus_if.APB_paddr;
                    bus_if.APB_perr   = (bus_if.APB_paddr[31:28] == 4'hE);
                end else begin
                    bus_if.APB_pready = 1'b0;
                    bus_if.APB_prdata = '0;
                    bus_if.APB_perr   = 1'b0;
                end
                acc++;
            end else begin
                bus_if.APB_pready = 1'b0;
                bus_if.APB_prdata = '0;
                bus_if.APB_perr   = 1'b0;
                acc = 0;
            end
        end
    end

    initial begin : monitor
        resp_t       r;
        bus_t        b;
        int          last_done;
        logic        pr [2];
        logic        pe [2];
        logic [31:0] pd [2];
        last_done = -100;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) continue;
            if (bus_if.APB_psel && !bus_if.APB_penable) begin
                if (exp_b.size() == 0) begin
                    chk("unexpected_setup", 128'(bus_if.APB_psel), 128'(0));
                end else begin
                    b = exp_b.pop_front();
                    $display("setup  owner=%0d addr=%h data=%h wr=%0d stb=%b cyc=%0d",
                             bus_if.grant, bus_if.APB_paddr, bus_if.APB_pdata,
                             bus_if.APB_pwrite, bus_if.APB_pstb, cyc);
                    chk("setup_fields",
                        128'({bus_if.grant, bus_if.APB_paddr, bus_if.APB_pdata,
                              bus_if.APB_pwrite, bus_if.APB_pstb}),
                        128'({b.owner, b.addr, b.data, b.wr, b.stb}));
                    if (b.at >= 0) chk("setup_cycle", 128'(cyc), 128'(b.at));
                    if (b.b2b)     chk("setup_back_to_back", 128'(cyc), 128'(last_done + 1));
                end
            end
            pr[0] = bus_if.m0_pready; pe[0] = bus_if.m0_perr; pd[0] = bus_if.m0_prdata;
            pr[1] = bus_if.m1_pready; pe[1] = bus_if.m1_perr; pd[1] = bus_if.m1_prdata;
            for (int m = 0; m < 2; m++) begin
                if (pr[m]) begin
                    last_done = cyc;
                    if ((m == 0 && exp_r0.size() == 0) || (m == 1 && exp_r1.size() == 0)) begin
                        chk($sformatf("m%0d_unexpected_pready", m), 128'(pr[m]), 128'(0));
                    end else begin
                        if (m == 0) r = exp_r0.pop_front();
                        else        r = exp_r1.pop_front();
                        $display("resp   m%0d rdata=%h err=%0d cyc=%0d", m, pd[m], pe[m], cyc);
                        chk($sformatf("m%0d_resp", m), 128'({pd[m], pe[m]}), 128'({r.rdata, r.err}));
                        if (r.at >= 0) chk($sformatf("m%0d_resp_cycle", m), 128'(cyc), 128'(r.at));
                    end
                end else begin
                    chk($sformatf("m%0d_quiet", m), 128'({pd[m], pe[m]}), 128'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0;
        clear_masters();
        #1;
        rst_n = 1'b0;
        #2;
        chk("reset_bus_ctrl",
            128'({bus_if.APB_psel, bus_if.APB_penable, bus_if.APB_pwrite, bus_if.APB_pstb, bus_if.grant}),
            128'(0));
        chk("reset_bus_addr_data", 128'({bus_if.APB_paddr, bus_if.APB_pdata}), 128'(0));
        chk("reset_master_resp",
            128'({bus_if.m0_pready, bus_if.m0_perr, bus_if.m0_prdata,
                  bus_if.m1_pready, bus_if.m1_perr, bus_if.m1_prdata}),
            128'(0));

        // Single m0 read, zero-wait slave.
        do_reset();
        t0 = cyc;
        exp_bus(1'b0, 32'h0000_0000, 32'h0, 1'b0, 4'hF, t0 + 1, 1'b0);
        exp_resp(0, 32'hDEADBEEF, 1'b0, t0 + 2);
        fork
            master_xfer(0, 32'h0000_0000, 32'h0, 1'b0, 4'hF, 1'b0);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                #1;
                chk("t1_access_phase", 128'({bus_if.APB_psel, bus_if.APB_penable}), 128'(2'b11));
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Both request from reset: m0 first, m1 write back-to-back.
        do_reset();
        t0 = cyc;
        exp_bus(1'b0, 32'h0000_0010, 32'h0, 1'b0, 4'hF, t0 + 1, 1'b0);
        exp_resp(0, 32'hDEADBEFF, 1'b0, t0 + 2);
        exp_bus(1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 4'b0011, t0 + 3, 1'b1);
        exp_resp(1, 32'hDEADBECF, 1'b0, t0 + 4);
        fork
            master_xfer(0, 32'h0000_0010, 32'h0, 1'b0, 4'hF, 1'b0);
            master_xfer(1, 32'h0000_0020, 32'h1234_5678, 1'b1, 4'b0011, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;

        // Both masters keep requesting: grants alternate 0,1,0,1.
        do_reset();
        t0 = cyc;
        exp_bus(1'b0, 32'h0000_0100, 32'h0000_00A0, 1'b1, 4'hF, t0 + 1, 1'b0);
        exp_resp(0, 32'hDEADBFEF, 1'b0, t0 + 2);
        exp_bus(1'b1, 32'h0000_0200, 32'h0000_00B0, 1'b0, 4'hF, t0 + 3, 1'b1);
        exp_resp(1, 32'hDEADBCEF, 1'b0, t0 + 4);
        exp_bus(1'b0, 32'h0000_0300, 32'h0000_00A1, 1'b1, 4'h3, t0 + 5, 1'b1);
        exp_resp(0, 32'hDEADBDEF, 1'b0, t0 + 6);
        exp_bus(1'b1, 32'h0000_0400, 32'h0000_00B1, 1'b0, 4'hC, t0 + 7, 1'b1);
        exp_resp(1, 32'hDEADBAEF, 1'b0, t0 + 8);
        fork
            begin
                master_xfer(0, 32'h0000_0100, 32'h0000_00A0, 1'b1, 4'hF, 1'b1);
                master_xfer(0, 32'h0000_0300, 32'h0000_00A1, 1'b1, 4'h3, 1'b0);
            end
            begin
                master_xfer(1, 32'h0000_0200, 32'h0000_00B0, 1'b0, 4'hF, 1'b1);
                master_xfer(1, 32'h0000_0400, 32'h0000_00B1, 1'b0, 4'hC, 1'b0);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Slave never answers: abort after TIMEOUT access cycles.
        do_reset();
        slave_hang = 1'b1;
        t0 = cyc;
        exp_bus(1'b0, 32'h0000_0040, 32'h0000_0055, 1'b1, 4'hF, t0 + 1, 1'b0);
        exp_resp(0, 32'h0, 1'b1, t0 + 5);
        master_xfer(0, 32'h0000_0040, 32'h0000_0055, 1'b1, 4'hF, 1'b0);
        chk("t4_psel_after_timeout", 128'({bus_if.APB_psel, bus_if.APB_penable}), 128'(0));
        slave_hang = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Slave error with two wait states on m0; m1 gets a clean response afterwards.
        do_reset();
        slave_wait = 2;
        t0 = cyc;
        exp_bus(1'b0, 32'hE000_0010, 32'h0, 1'b0, 4'hF, t0 + 1, 1'b0);
        exp_resp(0, 32'h3EADBEFF, 1'b1, t0 + 4);
        exp_bus(1'b1, 32'h0000_0020, 32'h0000_0077, 1'b1, 4'hF, t0 + 5, 1'b1);
        exp_resp(1, 32'hDEADBECF, 1'b0, t0 + 8);
        fork
            master_xfer(0, 32'hE000_0010, 32'h0, 1'b0, 4'hF, 1'b0);
            master_xfer(1, 32'h0000_0020, 32'h0000_0077, 1'b1, 4'hF, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-ACCESS: outputs clear immediately, then the pending m1 is served.
        do_reset();
        slave_hang = 1'b1;
        t0 = cyc;
        exp_bus(1'b0, 32'h0000_0500, 32'h0, 1'b0, 4'hF, t0 + 1, 1'b0);
        bus_if.m0_paddr = 32'h0000_0500; bus_if.m0_pdata = 32'h0; bus_if.m0_pwrite = 1'b0;
        bus_if.m0_pstb = 4'hF; bus_if.m0_psel = 1'b1;
        bus_if.m1_paddr = 32'h0000_0600; bus_if.m1_pdata = 32'h0000_0066; bus_if.m1_pwrite = 1'b1;
        bus_if.m1_pstb = 4'hF; bus_if.m1_psel = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("t6_in_access", 128'({bus_if.APB_psel, bus_if.APB_penable, bus_if.grant}), 128'(3'b110));
        rst_n = 1'b0;
        #1;
        chk("t6_async_bus_ctrl",
            128'({bus_if.APB_psel, bus_if.APB_penable, bus_if.APB_pwrite, bus_if.APB_pstb, bus_if.grant}),
            128'(0));
        chk("t6_async_addr_data", 128'({bus_if.APB_paddr, bus_if.APB_pdata}), 128'(0));
        chk("t6_async_master_resp",
            128'({bus_if.m0_pready, bus_if.m0_perr, bus_if.m0_prdata,
                  bus_if.m1_pready, bus_if.m1_perr, bus_if.m1_prdata}),
            128'(0));
        bus_if.m0_psel = 1'b0;
        slave_hang = 1'b0;
        exp_bus(1'b1, 32'h0000_0600, 32'h0000_0066, 1'b1, 4'hF, -1, 1'b0);
        exp_resp(1, 32'hDEADB8EF, 1'b0, -1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        master_xfer(1, 32'h0000_0600, 32'h0000_0066, 1'b1, 4'hF, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("leftover_expectations", 128'(exp_r0.size() + exp_r1.size() + exp_b.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
